// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum readout block.
// The optional HDR/TRL framing states exist only with SPECTRUM_READOUT_FRAME_EN.
package spectrum_pkg;

  localparam int unsigned ADDR_W           = 10;
  localparam int unsigned COUNT_W          = 32;
  localparam int unsigned NUM_CHANNELS_DEF = 1024;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned NBYTES_W         = 3;

  localparam logic [BYTE_W-1:0] HDR_BYTE0 = 8'hA5;
  localparam logic [BYTE_W-1:0] HDR_BYTE1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_NEXT,
    ST_FINISH
`ifdef SPECTRUM_READOUT_FRAME_EN
    ,
    ST_HDR,
    ST_TRL
`endif
  } readout_state_t;

  // XOR of the four bytes of one channel count
  function automatic logic [BYTE_W-1:0] xor_fold(input logic [COUNT_W-1:0] count);
    return count[31:24] ^ count[23:16] ^ count[15:8] ^ count[7:0];
  endfunction

endpackage

// File: rtl/spectrum_byte_serializer.sv
// Emits up to four bytes of a left-aligned 32-bit word, MSB first, on a
// valid/ready handshake; o_last_c flags the final byte of the load.
module spectrum_byte_serializer
  import spectrum_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [COUNT_W-1:0]  i_data,
  input  logic [NBYTES_W-1:0] i_nbytes,
  input  logic                i_ready,
  output logic [BYTE_W-1:0]   o_data,
  output logic                o_valid,
  output logic                o_last_c
);

  logic [COUNT_W-1:0]  r_shift;
  logic [NBYTES_W-1:0] r_left;
  logic                r_valid;

  // A load is only taken while idle; the held byte never moves during a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (r_valid) begin
      if (i_ready) begin
        if (r_left == NBYTES_W'(1)) begin
          r_valid <= 1'b0;
          r_shift <= '0;
          r_left  <= '0;
        end else begin
          r_shift <= {r_shift[COUNT_W-BYTE_W-1:0], BYTE_W'(0)};
          r_left  <= r_left - NBYTES_W'(1);
        end
      end
    end else if (i_load) begin
      r_shift <= i_data;
      r_left  <= i_nbytes;
      r_valid <= (i_nbytes != '0);
    end
  end

  assign o_data   = r_shift[COUNT_W-1 -: BYTE_W];
  assign o_valid  = r_valid;
  assign o_last_c = r_valid & (r_left == NBYTES_W'(1));

endmodule

// File: rtl/spectrum_readout.sv
// Sweeps the histogram RAM and streams every channel count as 4 bytes MSB first.
// Define SPECTRUM_READOUT_FRAME_EN to wrap the stream in an A5 5A header and an XOR trailer.
module spectrum_readout
  import spectrum_pkg::*;
#(
  parameter int unsigned RAM_LATENCY  = 2,
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF
) (
  input  logic               CLOCK_65,
  input  logic               rst,
  input  logic               cmd_read,
  output logic [ADDR_W-1:0]  ram_address,
  input  logic [COUNT_W-1:0] ram_q,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done
);

  localparam int unsigned       WAIT_W    = $clog2(RAM_LATENCY + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CHANNELS - 1);

  readout_state_t      r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_busy;
  logic                r_done;
`ifdef SPECTRUM_READOUT_FRAME_EN
  logic [BYTE_W-1:0]   r_csum;
`endif

  logic                w_load;
  logic [COUNT_W-1:0]  w_load_data;
  logic [NBYTES_W-1:0] w_load_nbytes;
  logic                w_tx_valid;
  logic                w_last_c;
  logic                w_last_xfer;

  // Serializer load requests: channel capture, plus header/trailer when framed
  always_comb begin
    w_load        = 1'b0;
    w_load_data   = ram_q;
    w_load_nbytes = NBYTES_W'(4);
    case (r_state)
      ST_FETCH: w_load = (r_wait == WAIT_W'(RAM_LATENCY));
`ifdef SPECTRUM_READOUT_FRAME_EN
      ST_IDLE: begin
        if (cmd_read) begin
          w_load        = 1'b1;
          w_load_data   = {HDR_BYTE0, HDR_BYTE1, (COUNT_W-2*BYTE_W)'(0)};
          w_load_nbytes = NBYTES_W'(2);
        end
      end
      ST_NEXT: begin
        if (r_addr == LAST_ADDR) begin
          w_load        = 1'b1;
          w_load_data   = {r_csum, (COUNT_W-BYTE_W)'(0)};
          w_load_nbytes = NBYTES_W'(1);
        end
      end
`endif
      default: ;
    endcase
  end

  assign w_last_xfer = w_tx_valid & tx_ready & w_last_c;

  always_ff @(posedge CLOCK_65 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wait  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SPECTRUM_READOUT_FRAME_EN
      r_csum  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_addr <= '0;
          if (cmd_read) begin
            r_busy <= 1'b1;
            r_wait <= '0;
`ifdef SPECTRUM_READOUT_FRAME_EN
            r_csum  <= '0;
            r_state <= ST_HDR;
`else
            r_state <= ST_FETCH;
`endif
          end
        end
`ifdef SPECTRUM_READOUT_FRAME_EN
        ST_HDR: if (w_last_xfer) r_state <= ST_FETCH;
        ST_TRL: if (w_last_xfer) r_state <= ST_FINISH;
`endif
        // Address is held while the RAM pipeline settles
        ST_FETCH: begin
          if (r_wait == WAIT_W'(RAM_LATENCY)) begin
            r_state <= ST_SEND;
`ifdef SPECTRUM_READOUT_FRAME_EN
            r_csum  <= r_csum ^ xor_fold(ram_q);
`endif
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_SEND: if (w_last_xfer) r_state <= ST_NEXT;
        ST_NEXT: begin
          r_wait <= '0;
          if (r_addr == LAST_ADDR) begin
`ifdef SPECTRUM_READOUT_FRAME_EN
            r_state <= ST_TRL;
`else
            r_state <= ST_FINISH;
`endif
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= ST_FETCH;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_addr  <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  spectrum_byte_serializer u_ser (
    .clk      (CLOCK_65),
    .rst      (rst),
    .i_load   (w_load),
    .i_data   (w_load_data),
    .i_nbytes (w_load_nbytes),
    .i_ready  (tx_ready),
    .o_data   (tx_data),
    .o_valid  (w_tx_valid),
    .o_last_c (w_last_c)
  );

  assign tx_valid    = w_tx_valid;
  assign ram_address = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
